// File: rtl/complex_divider.sv
// Iterative fixed-point complex divider: q = a*conj(b) / |b|^2.
// One operation at a time: products, sums, then two restoring dividers
// (real and imaginary) run in lockstep, one quotient bit per clock.
module complex_divider #(
  parameter int OPERAND_WIDTH_A   = 16,
  parameter int OPERAND_WIDTH_B   = 16,
  parameter int OPERAND_WIDTH_OUT = 16,
  parameter int FRAC_BITS         = 14,
  parameter int BYTE_ALIGNED      = 1,
  localparam int EFF_A   = (BYTE_ALIGNED != 0) ? ((2*OPERAND_WIDTH_A   + 15) / 16) * 16 : 2*OPERAND_WIDTH_A,
  localparam int EFF_B   = (BYTE_ALIGNED != 0) ? ((2*OPERAND_WIDTH_B   + 15) / 16) * 16 : 2*OPERAND_WIDTH_B,
  localparam int EFF_OUT = (BYTE_ALIGNED != 0) ? ((2*OPERAND_WIDTH_OUT + 15) / 16) * 16 : 2*OPERAND_WIDTH_OUT
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [EFF_A-1:0]   s_axis_a_tdata,
  input  logic               s_axis_a_tvalid,
  output logic               s_axis_a_tready,
  input  logic [EFF_B-1:0]   s_axis_b_tdata,
  input  logic               s_axis_b_tvalid,
  output logic               s_axis_b_tready,
  output logic [EFF_OUT-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tuser,
  output logic               m_axis_dout_tvalid,
  input  logic               m_axis_dout_tready
);

  localparam int WA   = OPERAND_WIDTH_A;
  localparam int WB   = OPERAND_WIDTH_B;
  localparam int W    = OPERAND_WIDTH_OUT;
  localparam int F    = FRAC_BITS;
  localparam int HA   = EFF_A / 2;
  localparam int HB   = EFF_B / 2;
  localparam int HO   = EFF_OUT / 2;
  localparam int PW   = WA + WB;          // cross-product width
  localparam int NW   = PW + 1;           // numerator width (signed)
  localparam int DW   = 2 * WB;           // denominator width (unsigned)
  localparam int XW   = NW + F;           // scaled numerator magnitude
  localparam int YW   = DW + W - 1;       // overflow threshold DEN*2^(W-1)
  localparam int CW   = ((XW > YW) ? XW : YW) + 1;
  localparam int CNTW = $clog2(W - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(W - 2);
  localparam logic [W-2:0]    MAG_MAX  = '1;

  typedef enum logic [2:0] {S_IDLE, S_PROD, S_SUM, S_DIV, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic signed [WA-1:0]  a_r_q, a_r_d, a_i_q, a_i_d;
  logic signed [WB-1:0]  b_r_q, b_r_d, b_i_q, b_i_d;
  logic signed [PW-1:0]  p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ir_q, p_ir_d, p_ri_q, p_ri_d;
  logic signed [DW-1:0]  p_br_q, p_br_d, p_bi_q, p_bi_d;
  logic                  neg_r_q, neg_r_d, neg_i_q, neg_i_d;
  logic                  ovf_r_q, ovf_r_d, ovf_i_q, ovf_i_d;
  logic                  dz_q, dz_d;
  logic [CW-1:0]         rem_r_q, rem_r_d, rem_i_q, rem_i_d, dsh_q, dsh_d;
  logic [W-2:0]          quo_r_q, quo_r_d, quo_i_q, quo_i_d;
  logic [EFF_OUT-1:0]    tdata_q, tdata_d;
  logic                  tuser_q, tuser_d;

  // Combinational helpers
  logic                  accept;
  logic signed [NW-1:0]  num_r_w, num_i_w;
  logic [NW-1:0]         mag_r_w, mag_i_w;
  logic [DW-1:0]         den_w;
  logic [CW-1:0]         x_r_w, x_i_w, lim_w;
  logic                  ge_r_w, ge_i_w;
  logic [W-2:0]          quo_r_nx, quo_i_nx, qmag_r_w, qmag_i_w;
  logic signed [W-1:0]   res_r_w, res_i_w;

  // Padding lanes carry only sign extension; they are intentionally ignored.
  if (HA > WA) begin : g_pad_a
    logic unused_pad_a;
    assign unused_pad_a = ^{s_axis_a_tdata[EFF_A-1:HA+WA], s_axis_a_tdata[HA-1:WA]};
  end
  if (HB > WB) begin : g_pad_b
    logic unused_pad_b;
    assign unused_pad_b = ^{s_axis_b_tdata[EFF_B-1:HB+WB], s_axis_b_tdata[HB-1:WB]};
  end

  // Both streams are taken together, and only while idle and out of reset.
  assign accept          = aresetn & (state_q == S_IDLE) & s_axis_a_tvalid & s_axis_b_tvalid;
  assign s_axis_a_tready = accept;
  assign s_axis_b_tready = accept;

  assign m_axis_dout_tvalid = (state_q == S_OUT);
  assign m_axis_dout_tdata  = tdata_q;
  assign m_axis_dout_tuser  = tuser_q;

  // Next-state and datapath: operand capture, products, sums, division steps.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_r_d   = a_r_q;   a_i_d  = a_i_q;   b_r_d  = b_r_q;   b_i_d  = b_i_q;
    p_rr_d  = p_rr_q;  p_ii_d = p_ii_q;  p_ir_d = p_ir_q;  p_ri_d = p_ri_q;
    p_br_d  = p_br_q;  p_bi_d = p_bi_q;
    neg_r_d = neg_r_q; neg_i_d = neg_i_q;
    ovf_r_d = ovf_r_q; ovf_i_d = ovf_i_q;
    dz_d    = dz_q;
    rem_r_d = rem_r_q; rem_i_d = rem_i_q; dsh_d = dsh_q;
    quo_r_d = quo_r_q; quo_i_d = quo_i_q;
    tdata_d = tdata_q;
    tuser_d = tuser_q;

    // Numerators, denominator and their magnitudes (used in SUM).
    num_r_w = NW'(p_rr_q) + NW'(p_ii_q);
    num_i_w = NW'(p_ir_q) - NW'(p_ri_q);
    den_w   = $unsigned(p_br_q) + $unsigned(p_bi_q);
    mag_r_w = num_r_w[NW-1] ? $unsigned(-num_r_w) : $unsigned(num_r_w);
    mag_i_w = num_i_w[NW-1] ? $unsigned(-num_i_w) : $unsigned(num_i_w);
    x_r_w   = CW'(mag_r_w) << F;
    x_i_w   = CW'(mag_i_w) << F;
    lim_w   = CW'(den_w) << (W - 1);

    // One restoring step per component against the shared shifted divisor.
    ge_r_w   = (rem_r_q >= dsh_q);
    ge_i_w   = (rem_i_q >= dsh_q);
    quo_r_nx = {quo_r_q[W-3:0], ge_r_w};
    quo_i_nx = {quo_i_q[W-3:0], ge_i_w};

    // Final result: saturate, apply sign, force zero on divide by zero.
    qmag_r_w = ovf_r_q ? MAG_MAX : quo_r_nx;
    qmag_i_w = ovf_i_q ? MAG_MAX : quo_i_nx;
    res_r_w  = neg_r_q ? -signed'({1'b0, qmag_r_w}) : signed'({1'b0, qmag_r_w});
    res_i_w  = neg_i_q ? -signed'({1'b0, qmag_i_w}) : signed'({1'b0, qmag_i_w});
    if (dz_q) begin
      res_r_w = '0;
      res_i_w = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_r_d   = s_axis_a_tdata[WA-1:0];
          a_i_d   = s_axis_a_tdata[HA +: WA];
          b_r_d   = s_axis_b_tdata[WB-1:0];
          b_i_d   = s_axis_b_tdata[HB +: WB];
          state_d = S_PROD;
        end
      end
      S_PROD: begin
        p_rr_d  = PW'(a_r_q) * PW'(b_r_q);
        p_ii_d  = PW'(a_i_q) * PW'(b_i_q);
        p_ir_d  = PW'(a_i_q) * PW'(b_r_q);
        p_ri_d  = PW'(a_r_q) * PW'(b_i_q);
        p_br_d  = DW'(b_r_q) * DW'(b_r_q);
        p_bi_d  = DW'(b_i_q) * DW'(b_i_q);
        state_d = S_SUM;
      end
      S_SUM: begin
        neg_r_d = num_r_w[NW-1];
        neg_i_d = num_i_w[NW-1];
        dz_d    = (den_w == '0);
        ovf_r_d = (x_r_w >= lim_w);
        ovf_i_d = (x_i_w >= lim_w);
        rem_r_d = x_r_w;
        rem_i_d = x_i_w;
        dsh_d   = CW'(den_w) << (W - 2);
        quo_r_d = '0;
        quo_i_d = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_r_d = ge_r_w ? (rem_r_q - dsh_q) : rem_r_q;
        rem_i_d = ge_i_w ? (rem_i_q - dsh_q) : rem_i_q;
        dsh_d   = dsh_q >> 1;
        quo_r_d = quo_r_nx;
        quo_i_d = quo_i_nx;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          tdata_d = {HO'(res_i_w), HO'(res_r_w)};
          tuser_d = dz_q;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (m_axis_dout_tready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers, cleared by synchronous reset.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      tdata_q <= '0;
      tuser_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tdata_q <= tdata_d;
      tuser_q <= tuser_d;
    end
  end

  // Datapath registers.
  // NOTE: no reset here; each is loaded before use, and the FSM reset alone discards an in-flight op.
  always_ff @(posedge aclk) begin
    cnt_q   <= cnt_d;
    a_r_q   <= a_r_d;   a_i_q  <= a_i_d;   b_r_q  <= b_r_d;   b_i_q  <= b_i_d;
    p_rr_q  <= p_rr_d;  p_ii_q <= p_ii_d;  p_ir_q <= p_ir_d;  p_ri_q <= p_ri_d;
    p_br_q  <= p_br_d;  p_bi_q <= p_bi_d;
    neg_r_q <= neg_r_d; neg_i_q <= neg_i_d;
    ovf_r_q <= ovf_r_d; ovf_i_q <= ovf_i_d;
    dz_q    <= dz_d;
    rem_r_q <= rem_r_d; rem_i_q <= rem_i_d; dsh_q <= dsh_d;
    quo_r_q <= quo_r_d; quo_i_q <= quo_i_d;
  end

endmodule

// File: tb/tb_complex_divider.sv
// Self-checking bench for complex_divider (default parameters): directed
// corner cases plus randomized operations against an integer reference model.
module tb_complex_divider;

  localparam int W = 16;
  localparam int F = 14;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] a_tdata = '0, b_tdata = '0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [31:0] dout;
  logic        tuser, tvalid;
  logic        tready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  complex_divider dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_axis_a_tdata     (a_tdata),
    .s_axis_a_tvalid    (a_valid),
    .s_axis_a_tready    (a_ready),
    .s_axis_b_tdata     (b_tdata),
    .s_axis_b_tvalid    (b_valid),
    .s_axis_b_tready    (b_ready),
    .m_axis_dout_tdata  (dout),
    .m_axis_dout_tuser  (tuser),
    .m_axis_dout_tvalid (tvalid),
    .m_axis_dout_tready (tready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference: complex division with plain integer arithmetic.
  // Returns {tuser, q_i[15:0], q_r[15:0]}.
  function automatic logic [32:0] ref_div(int ar, int ai, int br, int bi);
    longint nr, ni, den, qr, qi;
    nr  = longint'(ar) * br + longint'(ai) * bi;
    ni  = longint'(ai) * br - longint'(ar) * bi;
    den = longint'(br) * br + longint'(bi) * bi;
    if (den == 0) return {1'b1, 32'h0};
    qr = (nr * (longint'(1) << F)) / den;   // SV division truncates toward zero
    qi = (ni * (longint'(1) << F)) / den;
    if (qr >  32767) qr =  32767;
    if (qr < -32767) qr = -32767;
    if (qi >  32767) qi =  32767;
    if (qi < -32767) qi = -32767;
    return {1'b0, qi[15:0], qr[15:0]};
  endfunction

  // Offer an operation, measure latency, check result, optional backpressure.
  task automatic run_op(input int ar, input int ai, input int br, input int bi,
                        input int stall, input int only_a);
    logic [32:0] expv;
    int cyc;
    expv = ref_div(ar, ai, br, bi);
    @(negedge aclk);
    a_tdata = {ai[15:0], ar[15:0]};
    b_tdata = {bi[15:0], br[15:0]};
    a_valid = 1'b1;
    b_valid = (only_a == 0);
    for (int i = 0; i < only_a; i++) begin
      @(negedge aclk);
      check("one_valid_ready", {a_ready, b_ready, tvalid}, 3'b000);
    end
    b_valid = 1'b1;
    #1;
    check("accept_ready", {a_ready, b_ready}, 2'b11);
    @(posedge aclk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    cyc = 0;
    while (!tvalid && cyc < 100) begin
      @(posedge aclk);
      #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(W + 1));
    check("tdata", dout, expv[31:0]);
    check("tuser", tuser, expv[32]);
    if (stall > 0) begin
      a_tdata = $urandom;
      b_tdata = $urandom;
      a_valid = 1'b1;
      b_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge aclk);
        #1;
        check("stall_hold", {tvalid, tuser, dout, a_ready, b_ready}, {1'b1, expv, 2'b00});
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
    end
    tready = 1'b1;
    @(posedge aclk);
    #1;
    tready = 1'b0;
    check("tvalid_drop", tvalid, 1'b0);
  endtask

  // Start an op, reset in the middle of the division, confirm nothing emerges.
  task automatic reset_mid_div();
    int seen;
    @(negedge aclk);
    a_tdata = {16'sd0, 16'sd1000};
    b_tdata = {16'sd0, 16'sd3};
    a_valid = 1'b1;
    b_valid = 1'b1;
    @(posedge aclk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (8) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    check("rst_mid_tdata", {tvalid, tuser, dout}, 34'h0);
    seen = 0;
    tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge aclk);
      #1;
      if (tvalid) seen++;
    end
    tready = 1'b0;
    check("rst_mid_no_beat", 64'(seen), 64'(0));
  endtask

  initial begin
    int ar, ai, br, bi;
    // Reset with both streams offering data: nothing may be accepted.
    a_tdata = 32'h4000_4000;
    b_tdata = 32'h0000_4000;
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_out", {tvalid, tuser, dout}, 34'h0);
    check("reset_ready", {a_ready, b_ready}, 2'b00);
    a_valid = 1'b0;
    b_valid = 1'b0;
    aresetn = 1'b1;

    // Directed cases.
    run_op( 16384,      0, 16384,     0, 0, 0);
    run_op(-16384,  16384,     0, 16384, 0, 3);
    run_op(     0,   8192,     0, 16384, 0, 0);
    run_op(     1,      0,     3,     0, 0, 0);
    run_op(    -1,      0,     3,     0, 0, 0);
    run_op( 32767,      0,     1,     0, 0, 0);
    run_op(-32768, -32768,     1,     0, 0, 0);
    run_op(  1234,  -4321,     0,     0, 0, 0);
    run_op(  8192,      0, 16384,     0, 5, 0);
    reset_mid_div();
    run_op(  8192,      0, 16384,     0, 0, 0);

    // Randomized operations: full-range or small divisors to reach saturation.
    for (int n = 0; n < 40; n++) begin
      ar = int'($signed(16'($urandom)));
      ai = int'($signed(16'($urandom)));
      if ($urandom_range(0, 2) == 0) begin
        br = int'($urandom_range(0, 8)) - 4;
        bi = int'($urandom_range(0, 8)) - 4;
      end else begin
        br = int'($signed(16'($urandom)));
        bi = int'($signed(16'($urandom)));
      end
      run_op(ar, ai, br, bi, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
